// File: rtl/hazard_controller_pkg.sv
// Shared definitions for the core pipeline control blocks.
// Holds the memory-wait FSM state type, the R0 constant, the default
// data-memory wait length, the NOP control encoding loaded into ID/EXE on a
// bubble, and the register-match helper used by the hazard comparators.
package core_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mem_state_t;

    localparam logic [4:0]  R0               = 5'd0;
    localparam int unsigned DEFAULT_MEM_WAIT = 6;
    localparam int unsigned WAIT_W           = 4;

    // ID/EXE control bundle; a bubble loads NOP_CTRL (every enable low).
    typedef struct packed {
        logic wb_en;
        logic mem_r_en;
        logic mem_w_en;
        logic br_en;
    } idex_ctrl_t;

    localparam idex_ctrl_t NOP_CTRL = '0;

    // A producer matches a consumer only when it writes back a nonzero register.
    function automatic logic reg_match(
        input logic [4:0] src,
        input logic [4:0] dst,
        input logic       wb_en
    );
        return wb_en && (src == dst) && (dst != R0);
    endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// Pipeline <-> hazard controller bundle.
// master: pipeline side (drives register numbers, enables, requests;
//         receives freeze/bubble/flush controls and counters).
// slave : hazard_controller side.
interface hazard_controller_if #(
    parameter int unsigned CNT_W = 16
);
    logic             fwd_en;
    logic [4:0]       id_src1;
    logic [4:0]       id_src2;
    logic             id_src2_used;
    logic             id_br_taken;
    logic [4:0]       exe_dest;
    logic             exe_wb_en;
    logic             exe_mem_r_en;
    logic [4:0]       mem_dest;
    logic             mem_wb_en;
    logic             mem_req;

    logic             pc_freeze;
    logic             ifid_freeze;
    logic             idex_bubble;
    logic             ifid_flush;
    logic             pipe_freeze;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] freeze_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output fwd_en, id_src1, id_src2, id_src2_used, id_br_taken,
               exe_dest, exe_wb_en, exe_mem_r_en, mem_dest, mem_wb_en, mem_req,
        input  pc_freeze, ifid_freeze, idex_bubble, ifid_flush, pipe_freeze,
               stall_cnt, freeze_cnt, flush_cnt
    );

    modport slave (
        input  fwd_en, id_src1, id_src2, id_src2_used, id_br_taken,
               exe_dest, exe_wb_en, exe_mem_r_en, mem_dest, mem_wb_en, mem_req,
        output pc_freeze, ifid_freeze, idex_bubble, ifid_flush, pipe_freeze,
               stall_cnt, freeze_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_controller_mem_wait_fsm.sv
// Multi-cycle data-memory wait FSM.
// Ports: clk, rst (async, active high), mem_req (MEM-stage memory access),
//        mem_busy (pipeline must freeze this cycle).
// mem_busy is high for exactly MEM_WAIT cycles per access: the IDLE cycle in
// which the request appears plus MEM_WAIT-1 BUSY cycles. DONE is one free
// cycle in which the still-present request of the retiring access is ignored.
module mem_wait_fsm
    import core_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT = DEFAULT_MEM_WAIT
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_req,
    output logic mem_busy
);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MEM_WAIT - 2);

    mem_state_t        state, state_nxt;
    logic [WAIT_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (mem_req) begin
                    state_nxt = BUSY;
                    cnt_nxt   = WAIT_LOAD;
                end
            end
            BUSY: begin
                if (cnt == '0) state_nxt = DONE;
                else           cnt_nxt   = cnt - 1'b1;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Gated by rst so the freeze drops immediately on an asynchronous reset.
    assign mem_busy = !rst && (((state == IDLE) && mem_req) || (state == BUSY));

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller for the 5-stage core.
// Ports: clk, rst (async, active high), bus (hazard_controller_if.slave):
//   inputs  fwd_en, id_src1/2, id_src2_used, id_br_taken, exe_dest/wb_en/
//           mem_r_en, mem_dest/wb_en, mem_req
//   outputs pc_freeze, ifid_freeze, idex_bubble, ifid_flush, pipe_freeze and
//           saturating stall/freeze/flush counters.
// Priority: memory freeze > RAW stall > branch flush.
module hazard_controller
    import core_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT = DEFAULT_MEM_WAIT,
    parameter int unsigned CNT_W    = 16
) (
    input logic                clk,
    input logic                rst,
    hazard_controller_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic mem_busy;
    logic src1_exe, src2_exe, src1_mem, src2_mem;
    logic raw;
    logic [CNT_W-1:0] stall_q, freeze_q, flush_q;

    mem_wait_fsm #(
        .MEM_WAIT (MEM_WAIT)
    ) u_mem_wait_fsm (
        .clk      (clk),
        .rst      (rst),
        .mem_req  (bus.mem_req),
        .mem_busy (mem_busy)
    );

    assign src1_exe = reg_match(bus.id_src1, bus.exe_dest, bus.exe_wb_en);
    assign src2_exe = bus.id_src2_used && reg_match(bus.id_src2, bus.exe_dest, bus.exe_wb_en);
    assign src1_mem = reg_match(bus.id_src1, bus.mem_dest, bus.mem_wb_en);
    assign src2_mem = bus.id_src2_used && reg_match(bus.id_src2, bus.mem_dest, bus.mem_wb_en);

    // With forwarding only a load in EXE cannot be bypassed in time.
    always_comb begin
        raw = 1'b0;
        if (!rst) begin
            if (bus.fwd_en) raw = bus.exe_mem_r_en && (src1_exe || src2_exe);
            else            raw = src1_exe || src2_exe || src1_mem || src2_mem;
        end
    end

    assign bus.pipe_freeze = mem_busy;
    assign bus.pc_freeze   = mem_busy || raw;
    assign bus.ifid_freeze = mem_busy || raw;
    assign bus.idex_bubble = raw && !mem_busy;
    assign bus.ifid_flush  = !rst && bus.id_br_taken && !mem_busy && !raw;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q  <= '0;
            freeze_q <= '0;
            flush_q  <= '0;
        end else begin
            if (bus.idex_bubble && (stall_q != '1))  stall_q  <= stall_q + CNT_ONE;
            if (bus.pipe_freeze && (freeze_q != '1)) freeze_q <= freeze_q + CNT_ONE;
            if (bus.ifid_flush && (flush_q != '1))   flush_q  <= flush_q + CNT_ONE;
        end
    end

    assign bus.stall_cnt  = stall_q;
    assign bus.freeze_cnt = freeze_q;
    assign bus.flush_cnt  = flush_q;

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline sequencing block for the 5-stage MIPS core. It sits beside the decode stage and watches the decode source registers, the EXE/MEM destination registers, decode branch resolution and data-memory requests. From these it produces the freeze, bubble and flush controls for the PC, IF/ID, ID/EXE and EXE/MEM registers. It also owns the multi-cycle data-memory wait FSM and saturating stall/freeze/flush counters.

## Interface
Parameters:
- MEM_WAIT, 6: total freeze cycles per data-memory access; legal range 2..15.
- CNT_W, 16: width of each performance counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- fwd_en  in  1  1 = forwarding unit active; 0 = stall on every RAW hazard.
- id_src1  in  5  decode source register 1.
- id_src2  in  5  decode selected source register 2.
- id_src2_used  in  1  id_src2 is actually read; low for immediate ops other than store/bne.
- id_br_taken  in  1  decode resolved a taken branch.
- exe_dest  in  5  destination register of the instruction in EXE.
- exe_wb_en  in  1  write-back enable of that instruction.
- exe_mem_r_en  in  1  the EXE instruction is a load.
- mem_dest  in  5  destination register of the instruction in MEM.
- mem_wb_en  in  1  write-back enable of that instruction.
- mem_req  in  1  the MEM-stage instruction reads or writes data memory.
- pc_freeze  out  1  hold PC.
- ifid_freeze  out  1  hold IF/ID.
- idex_bubble  out  1  load a NOP (all enables 0) into ID/EXE.
- ifid_flush  out  1  clear IF/ID on the next edge.
- pipe_freeze  out  1  hold ID/EXE, EXE/MEM and MEM/WB.
- stall_cnt  out  CNT_W  cycles with idex_bubble high.
- freeze_cnt  out  CNT_W  cycles with pipe_freeze high.
- flush_cnt  out  CNT_W  cycles with ifid_flush high.

## Operation
- A register match requires equal register numbers, a nonzero register number and the producer's wb_en. R0 never matches.
- The src2 comparison applies only when id_src2_used = 1.
- RAW stall condition (raw):
  - fwd_en = 1: exe_mem_r_en and a match against exe_dest (load-use only).
  - fwd_en = 0: a match against exe_dest or against mem_dest.
- Memory FSM states: IDLE, BUSY, DONE.
  - IDLE to BUSY when mem_req = 1. The wait counter loads MEM_WAIT-2.
  - BUSY: counter decrements each cycle. At 0, go to DONE.
  - DONE: always returns to IDLE. mem_req is ignored in DONE because it still belongs to the retiring access.
- mem_busy = (state == IDLE and mem_req) or state == BUSY. mem_busy is therefore high for exactly MEM_WAIT cycles per access.
- Output priority is freeze, then stall, then flush:
  - pipe_freeze = mem_busy.
  - pc_freeze = ifid_freeze = mem_busy or raw.
  - idex_bubble = raw and not mem_busy.
  - ifid_flush = id_br_taken and not mem_busy and not raw. A branch whose operands are hazarded is resolved after the stall.
- Performance counters increment by 1 in each cycle that their output is high and saturate at all-ones.

## Timing
- All control outputs are combinational from the inputs and the registered FSM state, with no added latency. Hazards are visible in the same cycle.
- Reset (asynchronous): state IDLE, wait counter 0, all performance counters 0. All control outputs are 0 while rst is high, whatever the inputs.
- Load-use with fwd_en = 1: exactly one bubble. On the next cycle the load is in MEM and is no longer compared.
- No forwarding (fwd_en = 0): up to two bubble cycles per dependency.
- mem_req held high continuously (back-to-back memory instructions): the sequence is IDLE, BUSY x(MEM_WAIT-1), DONE, IDLE, and the next access begins freezing in that IDLE cycle. The gap between freezes is one cycle (DONE).
- raw during mem_busy: only the freeze is visible. The stall is re-evaluated after release.
- Reset asserted mid-BUSY: state returns to IDLE at once and freeze drops the same cycle.
- Changing fwd_en takes effect in the same cycle. It does not disturb the FSM.

## Structure
- Shared package core_ctrl_pkg holds:
  - the FSM state typedef (IDLE/BUSY/DONE);
  - the R0 constant;
  - the default MEM_WAIT;
  - the NOP control encoding used by idex_bubble.
- One sub-module, mem_wait_fsm, holds the state register and wait counter and outputs mem_busy.
- The hazard comparators and the performance counters stay in the top module.

## Test plan
- Load-use: fwd_en = 1, exe_mem_r_en = 1, exe_wb_en = 1, exe_dest = 5, id_src1 = 5 -> idex_bubble, pc_freeze and ifid_freeze high for 1 cycle; stall_cnt = 1.
- R0 and immediate: exe_dest = 0 matched against id_src1 = 0, and id_src2 = 7 matched against mem_dest = 7 with id_src2_used = 0 and fwd_en = 0 -> no stall.
- No forwarding: fwd_en = 0, mem_wb_en = 1, mem_dest = 3, id_src2 = 3, id_src2_used = 1 -> bubble asserted; cleared when mem_dest changes.
- Memory wait: MEM_WAIT = 6, mem_req pulsed with the pipeline otherwise idle -> pipe_freeze high for exactly 6 cycles, one DONE cycle, freeze_cnt = 6. Repeat with mem_req held high -> pattern of 6 freeze cycles, 1 free cycle.
- Priority: id_br_taken = 1 together with raw -> no flush; with mem_busy -> no flush and no bubble; branch alone -> ifid_flush for 1 cycle, flush_cnt = 1.
- Reset: rst asserted on the 3rd BUSY cycle -> all outputs 0 asynchronously, counters 0, and a fresh mem_req after release freezes for the full MEM_WAIT cycles.
